// File: rtl/pkg_config.sv
// Core-wide configuration: datapath widths and fetch-stage state encoding.
// Shared by the fetch stage and its instruction buffer.
// No logic; types and constants only.
package pkg_config;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,  // may issue a request for pc_q
        FETCH_WAIT = 2'd1,  // request granted, waiting for its response
        FETCH_DROP = 2'd2   // response in flight belongs to a squashed path
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry instruction buffer between fetch and decode.
// Latency: a load is visible on the outputs the cycle after the load edge.
// Backpressure: holds its entry until consume_i; flush_i drops it; load overrides consume.
//
// Ports: clk_i/rst_ni clock and synchronous active-low reset; load_i/instr_i/pc_i
// write a new entry; consume_i retires the entry; flush_i invalidates it;
// valid_o/instr_o/pc_o present the entry to decode.
module fetch_buffer
    import pkg_config::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0]  pc_i,
    input  logic                   consume_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0]  pc_o
);

    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0]  pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            // Only the valid bit is cleared; stale data is harmless.
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (consume_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem requests, one-entry decode buffer.
// Latency: zero-wait memory gives instr_valid_o two cycles after the request cycle.
// Backpressure: no request while the buffer is full and decode is not ready.
//
// Ports: clk_i/rst_ni clock and synchronous active-low reset; redirect_i/redirect_pc_i
// taken-branch redirect; imem_req_o/imem_addr_o/imem_gnt_i request channel;
// imem_rvalid_i/imem_rdata_i response channel; instr_valid_o/instr_o/pc_o/instr_ready_i
// buffered instruction handshake with decode.
module fetch_unit
    import pkg_config::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   redirect_i,
    input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
    output logic                   imem_req_o,
    output logic [DATA_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0]  pc_o,
    input  logic                   instr_ready_i
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  load;
    logic                  unused_redirect_lsb;

    // Target is word aligned by construction; low bits are dropped.
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Issue only when the buffer will be free by the time the response lands,
    // so a response never finds the buffer occupied.
    assign imem_req_o  = (state_q == FETCH_REQ) && (!instr_valid_o || instr_ready_i) && rst_ni;
    assign imem_addr_o = pc_q;

    // A response that coincides with a redirect belongs to the old path.
    assign load = (state_q == FETCH_WAIT) && imem_rvalid_i && !redirect_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;

        case (state_q)
            FETCH_REQ: begin
                if (imem_req_o && imem_gnt_i) begin
                    state_d = redirect_i ? FETCH_DROP : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH_REQ;
                end else if (redirect_i) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        if (redirect_i) begin
            pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        end else if (load) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer u_buffer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load),
        .instr_i   (imem_rdata_i),
        .pc_i      (pc_q),
        .consume_i (instr_ready_i),
        .flush_i   (redirect_i),
        .valid_o   (instr_valid_o),
        .instr_o   (instr_o),
        .pc_o      (pc_o)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    typedef struct {
        logic        rst_n, gnt, rvalid, ready, redir;
        logic [31:0] rdata, rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs; outputs are sampled 1ns later, well before the posedge.
    task automatic drive(input logic rst, input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        rst_ni        = rst;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    function automatic vec_t mk(logic rst, logic gnt, logic rv, logic [31:0] rd, logic rdy,
                                logic e_req, logic [31:0] e_addr, logic e_vld,
                                logic [31:0] e_instr, logic [31:0] e_pc);
        vec_t v;
        v.rst_n = rst; v.gnt = gnt; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.redir = 1'b0; v.rpc = 32'h0;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        // Reset, zero-wait fetch of 0x0, 5-cycle decode stall, then back-to-back fetches.
        vecs[0]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0, 32'h0); // in reset
        vecs[1]  = mk(1, 1, 0, 32'h0,        1, 1, 32'h0, 0, 32'h0, 32'h0); // first req 0x0
        vecs[2]  = mk(1, 0, 1, NOP,          1, 0, 32'h0, 0, 32'h0, 32'h0); // WAIT, rvalid
        vecs[3]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h4, 1, NOP,   32'h0); // valid, stall 1
        vecs[4]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h4, 1, NOP,   32'h0); // stall 2
        vecs[5]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h4, 1, NOP,   32'h0); // stall 3
        vecs[6]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h4, 1, NOP,   32'h0); // stall 4
        vecs[7]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h4, 1, NOP,   32'h0); // stall 5
        vecs[8]  = mk(1, 1, 0, 32'h0,        1, 1, 32'h4, 1, NOP,   32'h0); // ready back: req 0x4
        vecs[9]  = mk(1, 0, 1, 32'h0040_0093,1, 0, 32'h4, 0, 32'h0, 32'h0); // WAIT 0x4
        vecs[10] = mk(1, 1, 0, 32'h0,        1, 1, 32'h8, 1, 32'h0040_0093, 32'h4); // req 0x8
        vecs[11] = mk(1, 0, 1, 32'h0080_0113,1, 0, 32'h8, 0, 32'h0, 32'h0); // WAIT 0x8
        vecs[12] = mk(1, 0, 0, 32'h0,        1, 1, 32'hC, 1, 32'h0080_0113, 32'h8); // no grant
        vecs[13] = mk(1, 0, 1, 32'hDEAD_BEEF,0, 1, 32'hC, 0, 32'h0, 32'h0); // spurious rvalid
        vecs[14] = mk(1, 0, 0, 32'h0,        0, 1, 32'hC, 0, 32'h0, 32'h0); // still empty
        vecs[15] = mk(1, 0, 0, 32'h0,        1, 1, 32'hC, 0, 32'h0, 32'h0);

        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        step(); step();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst_n, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata,
                  vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("v%0d.req", i),   {31'h0, imem_req_o},    {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d.addr", i),  imem_addr_o,            vecs[i].e_addr);
            chk($sformatf("v%0d.valid", i), {31'h0, instr_valid_o}, {31'h0, vecs[i].e_vld});
            if (vecs[i].e_vld || !vecs[i].rst_n) begin
                chk($sformatf("v%0d.instr", i), instr_o, vecs[i].e_instr);
                chk($sformatf("v%0d.pc", i),    pc_o,    vecs[i].e_pc);
            end
            step();
        end

        // Redirect to 0x100 while waiting on 0x8; stale response arrives 3 cycles later.
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0); step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0); step();            // req 0x0
        drive(1, 0, 1, NOP, 1, 0, 32'h0);   step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0); step();            // req 0x4
        drive(1, 0, 1, NOP, 1, 0, 32'h0);   step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("r1.req8", imem_addr_o, 32'h8);
        step();                                                // WAIT for 0x8
        drive(1, 0, 0, 32'h0, 1, 1, 32'h100);
        chk("r1.req_in_wait", {31'h0, imem_req_o}, 32'h0);
        step();                                                // -> DROP
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("r1.drop_noreq", {31'h0, imem_req_o}, 32'h0);
        chk("r1.addr", imem_addr_o, 32'h100);
        step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0); step();
        drive(1, 1, 1, 32'h0000_0888, 1, 0, 32'h0);            // old 0x8 data
        chk("r1.drop_noreq2", {31'h0, imem_req_o}, 32'h0);
        step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("r1.valid_never", {31'h0, instr_valid_o}, 32'h0);
        chk("r1.req_new", {31'h0, imem_req_o}, 32'h1);
        chk("r1.addr_new", imem_addr_o, 32'h100);
        step();                                                // WAIT for 0x100

        // Redirect to 0x203 coinciding with the 0x100 response.
        drive(1, 0, 1, 32'h0000_0999, 1, 1, 32'h203); step();
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("r2.valid", {31'h0, instr_valid_o}, 32'h0);
        chk("r2.req", {31'h0, imem_req_o}, 32'h1);
        chk("r2.addr", imem_addr_o, 32'h200);

        // Redirect to 0x300 in the cycle 0x200 is granted.
        drive(1, 1, 0, 32'h0, 1, 1, 32'h300); step();          // -> DROP
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("r3.drop_noreq", {31'h0, imem_req_o}, 32'h0);
        chk("r3.addr", imem_addr_o, 32'h300);
        step();
        drive(1, 0, 1, 32'h0000_0AAA, 1, 0, 32'h0); step();    // old 0x200 data
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("r3.valid", {31'h0, instr_valid_o}, 32'h0);
        chk("r3.addr_new", imem_addr_o, 32'h300);
        step();
        drive(1, 0, 1, 32'h0000_0333, 1, 0, 32'h0); step();
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("r3.fetch_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("r3.fetch_instr", instr_o, 32'h0000_0333);
        chk("r3.fetch_pc", pc_o, 32'h300);

        // PC wrap: redirect to the last word while req is pending ungranted.
        drive(1, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC); step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("w.req", {31'h0, imem_req_o}, 32'h1);
        chk("w.addr", imem_addr_o, 32'hFFFF_FFFC);
        step();
        drive(1, 0, 1, 32'h0000_0FFF, 0, 0, 32'h0); step();
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("w.pc", pc_o, 32'hFFFF_FFFC);
        chk("w.instr", instr_o, 32'h0000_0FFF);
        chk("w.next_addr", imem_addr_o, 32'h0);

        // Reset while waiting on 0x40.
        drive(1, 0, 0, 32'h0, 1, 1, 32'h40); step();
        drive(1, 1, 0, 32'h0, 1, 0, 32'h0); step();            // WAIT for 0x40
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("rst.req_low", {31'h0, imem_req_o}, 32'h0);
        step();
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("rst.valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst.instr", instr_o, 32'h0);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.req", {31'h0, imem_req_o}, 32'h1);
        chk("rst.addr", imem_addr_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Holds the program counter, issues single-outstanding requests to instruction memory, and buffers one fetched instruction for decode. It consumes the branch unit's taken decision and resolved target as a redirect, flushing the buffered instruction and any in-flight response.

## Interface

Clocking and reset:
- One clock; reset is synchronous and active-low.
- Ports are named `clk_i` and `rst_ni`.

Parameters:
- `RESET_PC`, default `32'h0000_0000`. First fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  synchronous active-low reset
- `redirect_i`  in  1  taken branch/jump from branch unit (`take_o` path)
- `redirect_pc_i`  in  DATA_WIDTH  resolved target; bits [1:0] ignored (treated as 0)
- `imem_req_o`  out  1  memory request valid
- `imem_addr_o`  out  DATA_WIDTH  request address, word aligned
- `imem_gnt_i`  in  1  request accepted this cycle
- `imem_rvalid_i`  in  1  read data valid; at most one per granted request, earliest 1 cycle after grant
- `imem_rdata_i`  in  32  instruction word
- `instr_valid_o`  out  1  buffered instruction valid
- `instr_o`  out  32  buffered instruction
- `pc_o`  out  DATA_WIDTH  address of `instr_o`
- `instr_ready_i`  in  1  decode accepts buffer this cycle

## Operation

State and reset:
- State register `fetch_state_t`: `FETCH_REQ`, `FETCH_WAIT`, `FETCH_DROP`.
- Registers: `pc_q` (next fetch address), buffer (`instr_valid_o`, `instr_o`, `pc_o`).
- Reset values: state `FETCH_REQ`, `pc_q = RESET_PC`, `instr_valid_o = 0`, `instr_o = 0`, `pc_o = 0`. `imem_req_o` is 0 whenever `rst_ni = 0`.

Request side:
- `imem_addr_o = pc_q` at all times.
- `imem_req_o = (state == FETCH_REQ) && (!instr_valid_o || instr_ready_i) && rst_ni`.
- `FETCH_REQ`: `imem_req_o && imem_gnt_i` → `FETCH_WAIT`.
- `FETCH_WAIT`: on `imem_rvalid_i`, load the buffer with valid=1, `instr_o = imem_rdata_i`, `pc_o = pc_q`. In the same edge, `pc_q += 4` (wraps modulo 2^DATA_WIDTH) and state → `FETCH_REQ`.
- `FETCH_DROP`: on `imem_rvalid_i`, discard the data and go → `FETCH_REQ`. The buffer and `pc_q` are untouched.

Buffer:
- `instr_valid_o && instr_ready_i` clears valid, unless a load happens in the same edge.
- The issue rule guarantees the buffer is empty when a response arrives.

Redirect (highest priority, overrides all of the above):
- `pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}` and `instr_valid_o <= 0`.
- Next state:
  - from `FETCH_REQ` with grant this cycle → `FETCH_DROP`;
  - from `FETCH_REQ` without grant → `FETCH_REQ` (the address may change while req is pending ungranted);
  - from `FETCH_WAIT` without `imem_rvalid_i` → `FETCH_DROP`;
  - from `FETCH_WAIT` with `imem_rvalid_i` → data dropped, → `FETCH_REQ`;
  - from `FETCH_DROP` with `imem_rvalid_i` → `FETCH_REQ`, otherwise stay in `FETCH_DROP`.
- No instruction from an address issued before the redirect ever reaches `instr_valid_o`.

Other rules:
- `instr_ready_i` with `instr_valid_o = 0` is ignored.
- A spurious `imem_rvalid_i` in `FETCH_REQ` is ignored.

## Timing

- The first `imem_req_o` rises in the first cycle with `rst_ni = 1`.
- Zero-wait memory (grant same cycle, rvalid next cycle):
  - `instr_valid_o` rises 2 cycles after the request cycle;
  - sustained throughput is one instruction per 2 cycles with decode always ready.
- Redirect applied at edge N: the request for the target is issued in cycle N if idle-requesting, otherwise in the cycle after the outstanding response is dropped.
- All outputs are registered except `imem_req_o`, which is combinational from state, buffer valid, `instr_ready_i` and `rst_ni`.
- Reset asserted mid-request: the state returns to `FETCH_REQ` with no drop tracking. The memory must be reset in the same cycle.

## Structure

- `pkg_config`:
  - add `fetch_state_t` (2-bit enum);
  - add `INSTR_WIDTH = 32`;
  - reuse the existing `DATA_WIDTH`.
- `RESET_PC` stays a module parameter.
- One natural sub-module: `fetch_buffer` (single-entry valid/data/pc register with load, consume and flush). The FSM and PC stay in `fetch_unit`.

## Test plan

- **Reset then zero-wait memory returning `0x00000013` at every address:**
  - requests go to `0x0`, `0x4`, `0x8`;
  - `instr_valid_o` first high at cycle 2 with `pc_o = 0x0`;
  - one instruction every 2 cycles.
- **Decode stalled (`instr_ready_i = 0`) for 5 cycles after the first instruction:**
  - `imem_req_o` stays 0;
  - `instr_o` and `pc_o` stay stable;
  - the request for `0x4` is issued in the cycle ready returns.
- **Redirect to `0x100` while in `FETCH_WAIT` for `0x8`, rvalid 3 cycles later:**
  - the `0x8` data is never valid;
  - the next request address is `0x100`.
- **Redirect to `0x203` in the same cycle as rvalid:**
  - the data is dropped;
  - the next request is `0x200`;
  - the buffer is cleared.
- **Redirect in `FETCH_REQ` with `imem_gnt_i = 1` the same cycle:** goes to `FETCH_DROP`, and the response for the old address is discarded.
- **`pc_q = 0xFFFFFFFC` fetched:** the next request is `0x00000000`. Also, asserting `rst_ni = 0` mid-`FETCH_WAIT` gives `instr_valid_o = 0` and requests restart at `RESET_PC`.
